// File: rtl/instr_fetch_stage_pkg.sv
// Shared opcode constants, NOP encoding and fetch FSM state encoding.
// Imported by the fetch stage and the decode/control unit.
package instr_fetch_stage_pkg;

    localparam logic [1:0] OP_LI  = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_NOP = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    // NOP at the default 8-bit instruction width; wider cores build it from OP_NOP
    localparam logic [7:0] NOP_INSTR = {OP_NOP, 6'b0};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage_fetch_hold_buf.sv
// Single-entry {instr, pc} park slot for a fetch that returned while decode stalled.
// Loads/clears on the clock edge; load wins over clear; full marks a parked entry.
module fetch_hold_buf #(
    parameter int INSTR_W = 8,
    parameter int PC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic [INSTR_W-1:0] buf_instr,
    output logic [PC_W-1:0]    buf_pc,
    output logic               full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (load) begin
            full      <= 1'b1;
            buf_instr <= load_instr;
            buf_pc    <= load_pc;
        end else if (clear) begin
            full      <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, imem req/ready handshake, IF/ID register; 1 instr/cycle on zero-wait memory.
// Stall parks a returned fetch in the hold buffer; jump squashes wrong-path fetches.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int PC_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid
);

    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {(INSTR_W-2){1'b0}}};

    fetch_state_t       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    drain_addr;
    logic               buf_load;
    logic               buf_clear;
    logic               buf_full;
    logic [INSTR_W-1:0] buf_instr;
    logic [PC_W-1:0]    buf_pc;

    assign pc_inc    = pc + PC_W'(1);
    assign buf_load  = (state == ST_FETCH) && !jump_en && imem_ready && stall;
    assign buf_clear = (state == ST_HOLD) && (jump_en || !stall);

    fetch_hold_buf #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imem_rdata),
        .load_pc    (pc),
        .buf_instr  (buf_instr),
        .buf_pc     (buf_pc),
        .full       (buf_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc         <= '0;
            drain_addr <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            if_instr   <= NOP_WORD;
            if_pc      <= '0;
            if_valid   <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state     <= ST_FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end

                ST_FETCH: begin
                    if (jump_en) begin
                        pc       <= jump_target;
                        if_instr <= NOP_WORD;
                        if_valid <= 1'b0;
                        if (imem_ready) begin
                            imem_addr <= jump_target;
                        end else begin
                            // request already on the bus must finish at its old address
                            drain_addr <= pc;
                            state      <= ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        pc        <= pc_inc;
                        imem_addr <= pc_inc;
                        if (stall) begin
                            state    <= ST_HOLD;
                            imem_req <= 1'b0;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_instr <= NOP_WORD;
                        if_valid <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (jump_en) begin
                        pc        <= jump_target;
                        if_instr  <= NOP_WORD;
                        if_valid  <= 1'b0;
                        state     <= ST_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= jump_target;
                    end else if (!stall) begin
                        if_instr  <= buf_instr;
                        if_pc     <= buf_pc;
                        if_valid  <= buf_full;
                        state     <= ST_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end

                ST_DRAIN: begin
                    if (jump_en) begin
                        pc <= jump_target;
                    end
                    if (imem_ready) begin
                        state     <= ST_FETCH;
                        imem_addr <= jump_en ? jump_target : pc;
                    end else begin
                        imem_addr <= drain_addr;
                    end
                end

                default: begin
                    state    <= ST_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: wait-state memory model, IF/ID scoreboard, vector table and corner sequences.
module tb_instr_fetch_stage;

    localparam int INSTR_W = 8;
    localparam int PC_W    = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stall = 1'b0;
    logic               jump_en = 1'b0;
    logic [PC_W-1:0]    jump_target = '0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready = 1'b0;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_valid;

    instr_fetch_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    always #5 clk = ~clk;

    assign imem_rdata = 8'h40 | {2'b00, imem_addr};

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } sb_t;

    typedef struct {
        logic            stall;
        logic            jump;
        logic [PC_W-1:0] tgt;
        logic            req;
        logic [PC_W-1:0] addr;
        logic            valid;
        logic [7:0]      instr;
        logic [PC_W-1:0] pc;
    } vec_t;

    sb_t             exp_q[$];
    vec_t            vecs[9];
    int              mem_wait;
    int              wait_cnt;
    logic            squash;
    logic [PC_W-1:0] exp_fetch;
    logic [7:0]      exp_instr;
    logic [PC_W-1:0] exp_pc;
    logic            exp_valid;
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        squash    = 1'b0;
        exp_fetch = '0;
        exp_instr = 8'h80;
        exp_pc    = '0;
        exp_valid = 1'b0;
        wait_cnt  = 0;
    endtask

    // One clock: capture the cycle's inputs, advance, update the model, compare, then drive ready.
    task automatic step();
        logic            stall_c, jump_c, req_c, rdy_c;
        logic [PC_W-1:0] addr_c, tgt_c;
        sb_t             e;
        stall_c = stall;
        jump_c  = jump_en;
        tgt_c   = jump_target;
        req_c   = imem_req;
        rdy_c   = imem_ready;
        addr_c  = imem_addr;
        @(posedge clk);
        #1;
        jump_en = 1'b0;
        if (jump_c) begin
            exp_q.delete();
            if (req_c && !rdy_c) squash = 1'b1;
            else if (req_c && rdy_c) squash = 1'b0;
            exp_fetch = tgt_c;
            exp_instr = 8'h80;
            exp_valid = 1'b0;
        end else begin
            if (req_c && rdy_c) begin
                if (squash) begin
                    squash = 1'b0;
                end else begin
                    check("fetch_addr", addr_c, exp_fetch);
                    exp_q.push_back('{instr: 8'h40 | {2'b00, exp_fetch}, pc: exp_fetch});
                    exp_fetch = exp_fetch + 1'b1;
                end
            end
            if (!stall_c) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_instr = e.instr;
                    exp_pc    = e.pc;
                    exp_valid = 1'b1;
                end else begin
                    exp_instr = 8'h80;
                    exp_valid = 1'b0;
                end
            end
        end
        if (req_c && !rdy_c && imem_req) check("addr_stable", imem_addr, addr_c);
        check("sb_valid", if_valid, exp_valid);
        check("sb_instr", if_instr, exp_instr);
        if (exp_valid) check("sb_pc", if_pc, exp_pc);
        if (req_c && rdy_c) wait_cnt = 0;
        if (imem_req && wait_cnt >= mem_wait) begin
            imem_ready = 1'b1;
        end else begin
            imem_ready = 1'b0;
            if (imem_req) wait_cnt++;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!imem_ready && n < 10) begin
            step();
            n++;
        end
        check(name, imem_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        int n;

        vecs[0] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h00, 1'b0, 8'h80, 6'h00};
        vecs[1] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h01, 1'b1, 8'h40, 6'h00};
        vecs[2] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h02, 1'b1, 8'h41, 6'h01};
        vecs[3] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h03, 1'b1, 8'h42, 6'h02};
        vecs[4] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h04, 1'b1, 8'h43, 6'h03};
        vecs[5] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h05, 1'b1, 8'h44, 6'h04};
        vecs[6] = '{1'b0, 1'b1, 6'h20, 1'b1, 6'h20, 1'b0, 8'h80, 6'h00};
        vecs[7] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h21, 1'b1, 8'h60, 6'h20};
        vecs[8] = '{1'b0, 1'b0, 6'h00, 1'b1, 6'h22, 1'b1, 8'h61, 6'h21};

        mem_wait = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 6'h00);
        check("rst_instr", if_instr, 8'h80);
        check("rst_pc", if_pc, 6'h00);
        check("rst_valid", if_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait startup, then a jump to 0x20 while the fetch of pc=5 completes
        for (int i = 0; i < 9; i++) begin
            stall       = vecs[i].stall;
            jump_en     = vecs[i].jump;
            jump_target = vecs[i].tgt;
            step();
            check($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("vec%0d_valid", i), if_valid, vecs[i].valid);
            check($sformatf("vec%0d_instr", i), if_instr, vecs[i].instr);
            if (vecs[i].valid) check($sformatf("vec%0d_pc", i), if_pc, vecs[i].pc);
        end

        // PC wrap 0x3F -> 0x00
        jump_en = 1'b1; jump_target = 6'h3E;
        step();
        step();
        step();
        check("wrap_addr", imem_addr, 6'h00);
        check("wrap_pc_last", if_pc, 6'h3F);
        step();
        check("wrap_pc_zero", if_pc, 6'h00);
        check("wrap_instr_zero", if_instr, 8'h40);

        // Stall as the fetch of addr 3 returns
        jump_en = 1'b1; jump_target = 6'h02;
        step();
        step();
        check("stall_setup_addr", imem_addr, 6'h03);
        stall = 1'b1;
        step();
        check("stall_hold_pc", if_pc, 6'h02);
        check("stall_req_low", imem_req, 1'b0);
        step();
        check("stall_hold_pc2", if_pc, 6'h02);
        stall = 1'b0;
        step();
        check("release_pc", if_pc, 6'h03);
        check("release_instr", if_instr, 8'h43);
        check("release_req", imem_req, 1'b1);
        check("release_addr", imem_addr, 6'h04);
        step();
        check("after_release_pc", if_pc, 6'h04);

        // Jump while the addr-3 fetch sits in the hold buffer
        jump_en = 1'b1; jump_target = 6'h02;
        step();
        step();
        stall = 1'b1;
        step();
        jump_en = 1'b1; jump_target = 6'h30;
        step();
        check("hold_jump_valid", if_valid, 1'b0);
        check("hold_jump_instr", if_instr, 8'h80);
        check("hold_jump_addr", imem_addr, 6'h30);
        stall = 1'b0;
        step();
        check("hold_jump_pc", if_pc, 6'h30);
        check("hold_jump_data", if_instr, 8'h70);

        // Three wait cycles per fetch: one instruction every four cycles
        mem_wait = 3;
        repeat (4) step();
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (if_valid) vcnt++;
        end
        check("wait_rate", vcnt, 4);

        // Jump while the fetch of addr 7 is still pending
        wait_ready("drain_find_ready");
        jump_en = 1'b1; jump_target = 6'h07;
        step();
        check("drain_addr7", imem_addr, 6'h07);
        step();
        jump_en = 1'b1; jump_target = 6'h10;
        step();
        check("drain_hold_addr", imem_addr, 6'h07);
        check("drain_valid", if_valid, 1'b0);
        wait_ready("drain_ready");
        check("drain_ready_addr", imem_addr, 6'h07);
        step();
        check("drain_next_addr", imem_addr, 6'h10);
        check("drain_next_req", imem_req, 1'b1);
        check("drain_squash_valid", if_valid, 1'b0);
        wait_ready("target_ready");
        step();
        check("target_pc", if_pc, 6'h10);
        check("target_valid", if_valid, 1'b1);

        // Asynchronous reset mid-fetch with stall high, then a stray ready
        n = 0;
        while (!(imem_req && !imem_ready) && n < 10) begin
            step();
            n++;
        end
        check("mid_fetch_found", imem_req && !imem_ready, 1'b1);
        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", imem_req, 1'b0);
        check("arst_addr", imem_addr, 6'h00);
        check("arst_valid", if_valid, 1'b0);
        check("arst_instr", if_instr, 8'h80);
        check("arst_pc", if_pc, 6'h00);
        model_reset();
        mem_wait   = 0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_valid", if_valid, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b0;
        step();
        check("stray_valid", if_valid, 1'b0);
        check("stray_boot_addr", imem_addr, 6'h00);
        step();
        check("recover_pc", if_pc, 6'h00);
        check("recover_instr", if_instr, 8'h40);
        repeat (3) step();
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
